// File: rtl/count_mon_pkg.sv
// Shared types for the counter monitor: FSM state encoding and run-length width.
package count_mon_pkg;

    localparam int RUN_W = 8;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up counter; holds at all-ones once full, clear has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/sync_count_monitor.sv
// Observes a free-running up counter and reports lock, wrap and step errors.
// Optional ERR_STICKY output is enabled with `define COUNT_MON_STICKY_EN.
module sync_count_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int LOCK_LEN = 4,
    parameter int ERRW     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] Q_IN,
    output logic             LOCKED,
    output logic             WRAP,
    output logic             ERR,
`ifdef COUNT_MON_STICKY_EN
    output logic             ERR_STICKY,
`endif
    output logic [ERRW-1:0]  ERR_CNT
);

    localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_LEN);

    mon_state_t       state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_inc;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic             good;
    logic             prev_max;
    logic             err_evt;

    // Carry out of the increment is dropped so all-ones -> 0 is a good step.
    assign prev_inc = prev + 1'b1;
    assign run_inc  = run + 1'b1;
    assign good     = (Q_IN == prev_inc);
    assign prev_max = (prev == {WIDTH{1'b1}});
    assign err_evt  = (state == S_LOCK) && !good;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= S_INIT;
            prev   <= '0;
            run    <= '0;
            LOCKED <= 1'b0;
            WRAP   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            prev <= Q_IN;
            WRAP <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                S_INIT: state <= S_ACQ;
                S_ACQ: begin
                    if (good) begin
                        WRAP <= prev_max;
                        if (run_inc == LOCK_TGT) begin
                            state  <= S_LOCK;
                            LOCKED <= 1'b1;
                            run    <= '0;
                        end else begin
                            run <= run_inc;
                        end
                    end else begin
                        run <= '0;
                    end
                end
                S_LOCK: begin
                    if (good) begin
                        WRAP <= prev_max;
                    end else begin
                        ERR    <= 1'b1;
                        LOCKED <= 1'b0;
                        run    <= '0;
                        state  <= S_ACQ;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    sat_counter #(.W(ERRW)) u_err_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (err_evt),
        .clear (1'b0),
        .value (ERR_CNT)
    );

`ifdef COUNT_MON_STICKY_EN
    // Only reset clears it; counter saturation has no bearing.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR_STICKY <= 1'b0;
        end else if (err_evt) begin
            ERR_STICKY <= 1'b1;
        end
    end
`endif

endmodule
